seg_display_arbiter: RTL and testbench



---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg_display_arbiter_if.sv | 24 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg_display_arbiter.sv | 134 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display arbiter.
package seg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low anode enables; DIG0 is the leftmost digit
  localparam logic [3:0] AN_DIG0 = 4'b0111;
  localparam logic [3:0] AN_DIG1 = 4'b1011;
  localparam logic [3:0] AN_DIG2 = 4'b1101;
  localparam logic [3:0] AN_DIG3 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    VOL      = 2'd0,
    MSG_WAIT = 2'd1,
    MSG_SHOW = 2'd2
  } arb_state_e;

  // Anode pattern for a scan index
  function automatic logic [3:0] an_for_index(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_DIG0;
      2'd1:    an = AN_DIG1;
      2'd2:    an = AN_DIG2;
      default: an = AN_DIG3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bus of the 7-segment display arbiter.
interface seg_display_arbiter_if;

  logic [15:0] vol_digits;
  logic        msg_req;
  logic [15:0] msg_digits;
  logic        msg_grant;
  logic        msg_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  // Requesters and pin observers
  modport master (
    output vol_digits, msg_req, msg_digits,
    input  msg_grant, msg_done, an, seg
  );

  // The arbiter itself
  modport slave (
    input  vol_digits, msg_req, msg_digits,
    output msg_grant, msg_done, an, seg
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 blank.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  // Digit lookup
  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Scans a 4-digit 7-segment display and shares it between the volume meter
// and a message source; ownership only changes on frame boundaries.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 131072,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  seg_display_arbiter_if.slave  bus
);

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  arb_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       shadow_q, shadow_d;
  logic              grant_q, grant_d;
  logic              done_q, done_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              tick_c;
  logic              frame_end_c;
  logic [15:0]       src_c;
  logic [3:0]        nibble_c;
  logic [6:0]        seg_dec_c;

  // Digit-scan divider and frame boundary detect
  always_comb begin
    tick_c      = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end_c = tick_c && (idx_q == 2'd3);
    div_d       = tick_c ? '0 : div_q + DIV_W'(1);
  end

  // Arbiter FSM: grant and release only on frame_end
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    case (state_q)
      VOL: begin
        if (bus.msg_req && armed_q) state_d = MSG_WAIT;
      end
      MSG_WAIT: begin
        if (!bus.msg_req) begin
          state_d = VOL;
        end else if (frame_end_c) begin
          state_d  = MSG_SHOW;
          grant_d  = 1'b1;
          shadow_d = bus.msg_digits;
          hold_d   = HOLD_W'(HOLD_FRAMES);
          armed_d  = 1'b0;
        end
      end
      MSG_SHOW: begin
        if (frame_end_c) begin
          if (hold_q == HOLD_W'(1)) begin
            state_d = VOL;
            grant_d = 1'b0;
            done_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = VOL;
    endcase
    // A low request re-arms, so a stuck-high requester cannot re-grab the display
    if (!bus.msg_req) armed_d = 1'b1;
  end

  // Source select follows the next state so the grant edge already shows the message
  always_comb begin
    idx_d    = tick_c ? idx_q + 2'd1 : idx_q;
    src_c    = (state_d == MSG_SHOW) ? shadow_d : bus.vol_digits;
    nibble_c = src_c[3:0];
    case (idx_d)
      2'd0:    nibble_c = src_c[15:12];
      2'd1:    nibble_c = src_c[11:8];
      2'd2:    nibble_c = src_c[7:4];
      default: nibble_c = src_c[3:0];
    endcase
    an_d  = tick_c ? an_for_index(idx_d) : an_q;
    seg_d = tick_c ? seg_dec_c : seg_q;
  end

  bcd_to_seg7 u_dec (
    .bcd   (nibble_c),
    .seg_c (seg_dec_c)
  );

  // State and pin registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q    <= '0;
      idx_q    <= 2'd3;
      state_q  <= VOL;
      armed_q  <= 1'b1;
      hold_q   <= '0;
      shadow_q <= '0;
      grant_q  <= 1'b0;
      done_q   <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      armed_q  <= armed_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.msg_grant = grant_q;
  assign bus.msg_done  = done_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_seg_display_arbiter;

  localparam int unsigned SCAN_DIV    = 4;
  localparam int unsigned HOLD_FRAMES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_arbiter_if bus_if ();

  seg_display_arbiter #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       grant;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] an_of(input int idx);
    logic [3:0] a;
    case (idx)
      0: a = 4'b0111;
      1: a = 4'b1011;
      2: a = 4'b1101;
      default: a = 4'b1110;
    endcase
    return a;
  endfunction

  task automatic push(input int idx, input logic [3:0] dig, input logic grant, input logic done);
    exp_t e;
    e.an    = an_of(idx);
    e.seg   = seg_of(dig);
    e.grant = grant;
    e.done  = done;
    exp_q.push_back(e);
  endtask

  // Monitor: counts cycles since reset release; every SCAN_DIV-th edge is a tick
  always begin
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = 0;
    end else begin
      cyc++;
      n_checks++;
      if (cyc % SCAN_DIV == 0) begin
        got = {bus_if.an, bus_if.seg, bus_if.msg_grant, bus_if.msg_done};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scan_tick cyc=%0d: output an=%b seg=%b grant=%b done=%b with no expected entry",
                   cyc, got.an, got.seg, got.grant, got.done);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL scan_tick cyc=%0d: got an=%b seg=%b grant=%b done=%b, required an=%b seg=%b grant=%b done=%b",
                     cyc, got.an, got.seg, got.grant, got.done, e.an, e.seg, e.grant, e.done);
          end
        end
      end else if (bus_if.msg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_idle cyc=%0d: msg_done=%b required 0", cyc, bus_if.msg_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      int guard;
      guard = 0;
      step();
      while ((cyc % SCAN_DIV) != 0 && guard < 2 * SCAN_DIV) begin
        step();
        guard++;
      end
      if (guard >= 2 * SCAN_DIV) begin
        n_fail++;
        $display("FAIL tick_timeout: no tick after %0d cycles, cyc=%0d", guard, cyc);
      end
    end
  endtask

  task automatic test_reset();
    bus_if.vol_digits = 16'h0012;
    bus_if.msg_req    = 1'b0;
    bus_if.msg_digits = 16'h0000;
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bus_if.an !== 4'b1111) begin
      n_fail++; $display("FAIL reset_an: got %b required 1111", bus_if.an);
    end
    n_checks++;
    if (bus_if.seg !== 7'b1111111) begin
      n_fail++; $display("FAIL reset_seg: got %b required 1111111", bus_if.seg);
    end
    n_checks++;
    if (bus_if.msg_grant !== 1'b0) begin
      n_fail++; $display("FAIL reset_grant: got %b required 0", bus_if.msg_grant);
    end
    n_checks++;
    if (bus_if.msg_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b required 0", bus_if.msg_done);
    end
    @(negedge clk);
    rst = 1'b0;
    push(0, 4'h0, 1'b0, 1'b0);
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    wait_ticks(4);
  endtask

  task automatic test_msg_grant();
    step();
    bus_if.msg_req    = 1'b1;
    bus_if.msg_digits = 16'h9876;
    for (int f = 0; f < 2; f++) begin
      push(0, 4'h9, 1'b1, 1'b0);
      push(1, 4'h8, 1'b1, 1'b0);
      push(2, 4'h7, 1'b1, 1'b0);
      push(3, 4'h6, 1'b1, 1'b0);
    end
    push(0, 4'h0, 1'b0, 1'b1);
    wait_ticks(2);
    bus_if.msg_digits = 16'h1111;
    wait_ticks(7);
  endtask

  task automatic test_lockout();
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    push(0, 4'h0, 1'b0, 1'b0);
    wait_ticks(4);
    bus_if.msg_req = 1'b0;
    step();
    bus_if.msg_req    = 1'b1;
    bus_if.msg_digits = 16'h3405;
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    push(0, 4'h3, 1'b1, 1'b0);
    wait_ticks(4);
    bus_if.msg_req = 1'b0;
    push(1, 4'h4, 1'b1, 1'b0);
    push(2, 4'h0, 1'b1, 1'b0);
    push(3, 4'h5, 1'b1, 1'b0);
    push(0, 4'h3, 1'b1, 1'b0);
    push(1, 4'h4, 1'b1, 1'b0);
    push(2, 4'h0, 1'b1, 1'b0);
    push(3, 4'h5, 1'b1, 1'b0);
    push(0, 4'h0, 1'b0, 1'b1);
    wait_ticks(8);
  endtask

  task automatic test_aborted();
    step();
    bus_if.msg_req    = 1'b1;
    bus_if.msg_digits = 16'h8888;
    step();
    step();
    bus_if.msg_req = 1'b0;
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    push(0, 4'h0, 1'b0, 1'b0);
    wait_ticks(4);
  endtask

  task automatic test_blank();
    bus_if.vol_digits = 16'hA000;
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h0, 1'b0, 1'b0);
    push(3, 4'h0, 1'b0, 1'b0);
    push(0, 4'hA, 1'b0, 1'b0);
    wait_ticks(4);
    bus_if.vol_digits = 16'h0012;
  endtask

  task automatic test_mid_show_reset();
    bus_if.msg_req    = 1'b1;
    bus_if.msg_digits = 16'h1234;
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    push(0, 4'h1, 1'b1, 1'b0);
    wait_ticks(4);
    step();
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.an !== 4'b1111) begin
      n_fail++; $display("FAIL midreset_an: got %b required 1111", bus_if.an);
    end
    n_checks++;
    if (bus_if.seg !== 7'b1111111) begin
      n_fail++; $display("FAIL midreset_seg: got %b required 1111111", bus_if.seg);
    end
    n_checks++;
    if (bus_if.msg_grant !== 1'b0) begin
      n_fail++; $display("FAIL midreset_grant: got %b required 0", bus_if.msg_grant);
    end
    n_checks++;
    if (bus_if.msg_done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_done: got %b required 0", bus_if.msg_done);
    end
    bus_if.msg_req = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    push(0, 4'h0, 1'b0, 1'b0);
    push(1, 4'h0, 1'b0, 1'b0);
    push(2, 4'h1, 1'b0, 1'b0);
    push(3, 4'h2, 1'b0, 1'b0);
    wait_ticks(4);
  endtask

  initial begin
    test_reset();
    test_msg_grant();
    test_lockout();
    test_aborted();
    test_blank();
    test_mid_show_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
